d_to_t_ff: RTL and testbench
============================

# d_to_t_ff

Toggle (T) flip-flop built from a D flip-flop and next-state feedback logic, implementing the `d_to_t` design unit. On each rising clock edge, the stored bit inverts when `t` is high and holds when `t` is low. It is a leaf sequential primitive for counters, dividers and parity trackers. It can be parameterised to a vector of independent toggle bits.

## Interface

Parameters:
- `WIDTH`, default 1: number of independent toggle bits. `t` and `Q` are both `WIDTH` wide.
- `RESET_VALUE`, default `{WIDTH{1'b0}}`: value loaded into `Q` by reset.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  reset. One clock; reset is synchronous and active-high.
- `t`  input  `WIDTH`  per-bit toggle request, sampled at the rising edge of `clk`.
- `Q`  output  `WIDTH`  registered state, driven directly from the flop outputs.

## Operation

- Structure:
  - One D-type storage element per bit.
  - D input = `Q ^ t`, the toggle law expressed through D-flop feedback.
  - No combinational path from `t` to `Q`.
- Per bit, at each rising `clk` edge:
  - `rst`=1: `Q` <= `RESET_VALUE`, regardless of `t`.
  - `rst`=0, `t`=1: `Q` <= ~`Q`.
  - `rst`=0, `t`=0: `Q` <= `Q` (hold).
- Bits are fully independent. Toggling one bit never affects another.
- No enable, no asynchronous set/clear, no other state.
- `Q` is undefined (X in simulation) from power-up until the first rising edge at which `rst`=1. Benches must apply reset for at least one edge.

## Timing

- Latency: one cycle. `t` sampled at edge N affects `Q` immediately after edge N.
- Reset:
  - Takes effect only at a rising edge.
  - Asserting `rst` between edges does not change `Q` until the next edge.
  - Reset mid-toggle-sequence wins: `Q` = `RESET_VALUE` after that edge, and the toggle is discarded.
- Deassert: the first edge with `rst`=0 applies the normal `t` rule to the reset value.
- `t` held high continuously: `Q` toggles every cycle, i.e. a square wave at f_clk/2.
- `t` changes between edges: only the value present at the edge matters. Glitches between edges are ignored.
- `Q` changes only at rising edges, with no output change on falling edges.
- Setup/hold of `t` and `rst` are relative to the rising edge of `clk`. There is no timing requirement on the falling edge.

## Test plan

Use a 10-time-unit clock with `clk`=0 at t=0 and rising edges at 5, 15, 25, …; `WIDTH`=1 and `RESET_VALUE`=0.

1. Reset: `rst`=1, `t`=0 through the edge at 5 -> `Q`=0 after 5. Also with `t`=1 during reset -> `Q` stays 0.
2. Toggle burst: `rst`=0 from 10, `t`=1 from 20 to 40 -> `Q`=1 after edge 25, `Q`=0 after edge 35.
3. Hold: `t`=0 from 40 to 60 -> `Q` stays 0 across edges 45 and 55.
4. Continuous toggle: `t`=1 from 60 to 100 -> `Q` = 1, 0, 1, 0 after edges 65, 75, 85, 95. Then `t`=0 from 100 to 140 -> `Q` holds 0 through edge 135.
5. Reset mid-operation: with `Q`=1 and `t`=1, assert `rst` for one edge -> `Q`=0. Deassert with `t`=1 -> `Q`=1 after the next edge.
6. Vector independence (`WIDTH`=4, `RESET_VALUE`=4'b1010): reset -> `Q`=4'b1010. `t`=4'b0011 for one edge -> `Q`=4'b1001. `t`=4'b1111 for one edge -> `Q`=4'b0110.

Source files
------------

// File: rtl/d_to_t_ff.sv
// d_to_t_ff: toggle flip-flop built from a D register with XOR feedback.
// Each of the WIDTH bits inverts on a rising clk edge when its t bit is high
// and holds when low; reset is synchronous and loads RESET_VALUE.
//
// Ports:
//   clk  in   1      rising-edge clock
//   rst  in   1      synchronous active-high reset
//   t    in   WIDTH  per-bit toggle request, sampled at the rising edge
//   Q    out  WIDTH  registered state, straight from the flops
module d_to_t_ff #(
   parameter int unsigned             WIDTH       = 1,
   parameter logic [WIDTH-1:0]        RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] t,
   output logic [WIDTH-1:0] Q
);

   // D input of each storage bit: the toggle law folded into feedback.
   logic [WIDTH-1:0] d_c;

   assign d_c = Q ^ t;

   // Storage; reset wins over any pending toggle at the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         Q <= RESET_VALUE;
      end else begin
         Q <= d_c;
      end
   end

endmodule

// File: tb/tb_d_to_t_ff.sv
// Bench for d_to_t_ff: a 1-bit instance (reset value 0) and a 4-bit instance
// (reset value 4'b1010) run side by side. Expected state comes from counting
// toggle requests per bit since the last reset.
module tb_d_to_t_ff;

   localparam int unsigned W4 = 4;
   localparam logic [0:0]    RV1 = 1'b0;
   localparam logic [W4-1:0] RV4 = 4'b1010;

   logic          clk;
   logic          rst;
   logic [0:0]    t1;
   logic [0:0]    q1;
   logic [W4-1:0] t4;
   logic [W4-1:0] q4;

   int n_checks;
   int n_errors;

   // Reference: number of accepted toggles per bit since the last reset.
   int  cnt1;
   int  cnt4 [W4];
   bit  armed;

   d_to_t_ff u_dut1 (
      .clk (clk),
      .rst (rst),
      .t   (t1),
      .Q   (q1)
   );

   d_to_t_ff #(
      .WIDTH       (W4),
      .RESET_VALUE (RV4)
   ) u_dut4 (
      .clk (clk),
      .rst (rst),
      .t   (t4),
      .Q   (q4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [0:0] exp1();
      return RV1 ^ 1'((cnt1 % 2) != 0);
   endfunction

   function automatic logic [W4-1:0] exp4();
      logic [W4-1:0] v;
      for (int i = 0; i < int'(W4); i++) v[i] = RV4[i] ^ ((cnt4[i] % 2) != 0);
      return v;
   endfunction

   // One clock cycle: drive at the falling edge with a deliberate glitch,
   // confirm Q is unchanged between edges, then check after the rising edge.
   task automatic step(input logic r, input logic [0:0] ta, input logic [W4-1:0] tb, input string tag);
      @(negedge clk);
      rst = 1'b1;
      t1  = ~ta;
      t4  = ~tb;
      #2;
      rst = r;
      t1  = ta;
      t4  = tb;
      #1;
      if (armed) begin
         check({"mid1_", tag}, {3'b000, q1}, {3'b000, exp1()});
         check({"mid4_", tag}, q4, exp4());
      end
      @(posedge clk);
      if (r) begin
         armed = 1'b1;
         cnt1  = 0;
         for (int i = 0; i < int'(W4); i++) cnt4[i] = 0;
      end else begin
         cnt1 += int'(ta);
         for (int i = 0; i < int'(W4); i++) cnt4[i] += int'(tb[i]);
      end
      #1;
      if (armed) begin
         check({"q1_", tag}, {3'b000, q1}, {3'b000, exp1()});
         check({"q4_", tag}, q4, exp4());
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      armed    = 1'b0;
      cnt1     = 0;
      for (int i = 0; i < int'(W4); i++) cnt4[i] = 0;
      rst = 1'b0;
      t1  = 1'b0;
      t4  = '0;

      // Reset, with and without toggle requests present.
      step(1'b1, 1'b0, 4'b0000, "rst");
      check("rst_q1", {3'b000, q1}, 4'b0000);
      check("rst_q4", q4, 4'b1010);
      step(1'b1, 1'b1, 4'b1111, "rst_t");
      check("rst_t_q1", {3'b000, q1}, 4'b0000);
      check("rst_t_q4", q4, 4'b1010);

      // Toggle burst, then hold.
      step(1'b0, 1'b0, 4'b0000, "idle");
      step(1'b0, 1'b1, 4'b0000, "tog_a");
      check("burst1", {3'b000, q1}, 4'b0001);
      step(1'b0, 1'b1, 4'b0000, "tog_b");
      check("burst0", {3'b000, q1}, 4'b0000);
      step(1'b0, 1'b0, 4'b0000, "hold_a");
      step(1'b0, 1'b0, 4'b0000, "hold_b");
      check("hold0", {3'b000, q1}, 4'b0000);

      // Continuous toggle: square wave at half the clock rate.
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b1, 4'b0000, "cont");
         check("cont_q1", {3'b000, q1}, {3'b000, 1'((k % 2) == 0)});
      end
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 4'b0000, "cont_hold");
      check("cont_hold_q1", {3'b000, q1}, 4'b0000);

      // Reset wins over a pending toggle; first edge after release toggles.
      step(1'b0, 1'b1, 4'b0000, "pre_rst");
      check("pre_rst_q1", {3'b000, q1}, 4'b0001);
      step(1'b1, 1'b1, 4'b1111, "mid_rst");
      check("mid_rst_q1", {3'b000, q1}, 4'b0000);
      check("mid_rst_q4", q4, 4'b1010);
      step(1'b0, 1'b1, 4'b0011, "post_rst");
      check("post_rst_q1", {3'b000, q1}, 4'b0001);
      check("vec_0011", q4, 4'b1001);
      step(1'b0, 1'b0, 4'b1111, "vec_all");
      check("vec_1111", q4, 4'b0110);

      // Randomized traffic with occasional resets.
      for (int k = 0; k < 300; k++) begin
         step(1'(($urandom % 16) == 0), 1'($urandom), 4'($urandom), "rand");
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
